// File: rtl/overflow_event_tracker_pkg.sv
// Shared types and default widths for the overflow event tracker.
package overflow_tracker_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_VAL_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    ALERT    = 2'd2
  } state_t;

endpackage

// File: rtl/overflow_event_tracker_rise_detect.sv
// Rising-edge detector for a level flag: one-cycle pulse when d goes 0->1.
// A flag already high when reset releases produces a pulse on the first edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Delayed copy of the flag, tracked every cycle regardless of the consumer's state.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/overflow_event_tracker.sv
// Counts rising edges of the upstream overflow flag, snapshots the counter
// value at each counted event and raises a held interrupt at a threshold.
module overflow_event_tracker
  import overflow_tracker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int VAL_W = DEF_VAL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] counter_in,
  input  logic             overflow_in,
  input  logic             arm,
  input  logic [CNT_W-1:0] thresh,
  input  logic             ack,
  output logic [CNT_W-1:0] event_count,
  output logic [VAL_W-1:0] last_value,
  output logic             sat,
  output logic             irq,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             ev;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_ack;

  rise_detect u_ovf_rise (
    .clk   (clk),
    .reset (reset),
    .d     (overflow_in),
    .rise  (ev)
  );

  // Saturating increment; at all-ones the count simply holds.
  assign cnt_inc = (event_count == CNT_MAX) ? event_count : event_count + 1'b1;

  // Count after an ack: an event in the ack cycle still counts if we stay armed.
  assign cnt_ack = (arm && ev) ? CNT_W'(1) : '0;

  // Tracker FSM; all outputs registered, sat mirrors the all-ones count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      event_count <= '0;
      last_value  <= '0;
      sat         <= 1'b0;
      irq         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Events are ignored here, including one in the arming cycle.
          if (arm) begin
            state       <= COUNTING;
            busy        <= 1'b1;
            event_count <= '0;
            sat         <= 1'b0;
          end
        end
        COUNTING: begin
          if (ev) begin
            event_count <= cnt_inc;
            sat         <= &cnt_inc;
            last_value  <= counter_in;
          end
          // Disarm takes priority over a threshold hit in the same cycle.
          if (!arm) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (ev && (thresh != '0) && (cnt_inc == thresh)) begin
            state <= ALERT;
            irq   <= 1'b1;
          end
        end
        ALERT: begin
          if (ev) last_value <= counter_in;
          if (ack) begin
            irq         <= 1'b0;
            event_count <= cnt_ack;
            sat         <= &cnt_ack;
            state       <= arm ? COUNTING : IDLE;
            busy        <= arm;
          end else if (ev) begin
            event_count <= cnt_inc;
            sat         <= &cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_overflow_event_tracker.sv
// Directed scenarios followed by random traffic, checked against a
// cycle-level behavioural model of the tracker.
module tb_overflow_event_tracker;

  localparam int CW  = 3;
  localparam int VW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [VW-1:0] counter_in;
  logic          overflow_in;
  logic          arm;
  logic [CW-1:0] thresh;
  logic          ack;
  logic [CW-1:0] event_count;
  logic [VW-1:0] last_value;
  logic          sat;
  logic          irq;
  logic          busy;

  int vectors = 0;
  int errors  = 0;

  // model state: mode 0 = disarmed, 1 = counting, 2 = alert pending
  int m_mode = 0;
  int m_cnt  = 0;
  int m_last = 0;
  int m_irq  = 0;
  int m_prev = 0;

  overflow_event_tracker #(.CNT_W(CW), .VAL_W(VW)) dut (
    .clk         (clk),
    .reset       (reset),
    .counter_in  (counter_in),
    .overflow_in (overflow_in),
    .arm         (arm),
    .thresh      (thresh),
    .ack         (ack),
    .event_count (event_count),
    .last_value  (last_value),
    .sat         (sat),
    .irq         (irq),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare all outputs.
  task automatic step(input logic r, input logic a, input logic o, input logic k,
                      input logic [CW-1:0] th, input logic [VW-1:0] cv);
    int ev;
    @(negedge clk);
    reset = r; arm = a; overflow_in = o; ack = k; thresh = th; counter_in = cv;
    @(posedge clk);
    ev     = (o && m_prev == 0) ? 1 : 0;
    m_prev = r ? 0 : int'(o);
    if (r) begin
      m_mode = 0; m_cnt = 0; m_last = 0; m_irq = 0;
    end else if (m_mode == 0) begin
      if (a) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (ev == 1) begin
        m_cnt  = (m_cnt + 1 > MAX) ? MAX : m_cnt + 1;
        m_last = int'(cv);
      end
      if (!a) m_mode = 0;
      else if (ev == 1 && th != 0 && m_cnt == int'(th)) begin m_mode = 2; m_irq = 1; end
    end else begin
      if (ev == 1) begin
        m_cnt  = (m_cnt + 1 > MAX) ? MAX : m_cnt + 1;
        m_last = int'(cv);
      end
      if (k) begin
        m_irq  = 0;
        m_cnt  = (a && ev == 1) ? 1 : 0;
        m_mode = a ? 1 : 0;
      end
    end
    #1;
    chk("event_count", 32'(event_count), 32'(m_cnt));
    chk("last_value",  32'(last_value),  32'(m_last));
    chk("sat",         32'(sat),         (m_cnt == MAX) ? 32'd1 : 32'd0);
    chk("irq",         32'(irq),         32'(m_irq));
    chk("busy",        32'(busy),        (m_mode != 0) ? 32'd1 : 32'd0);
  endtask

  // Low-then-high pulse on the overflow flag while armed.
  task automatic pulse(input logic [CW-1:0] th, input logic [VW-1:0] cv, input logic a);
    step(0, a, 0, 0, th, cv);
    step(0, a, 1, 0, th, cv);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; overflow_in = 1'b0; ack = 1'b0;
    thresh = '0; counter_in = '0;

    // 1: flag high through reset; its first edge lands in the arming cycle
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 3'd3, 4'hF);
    chk("rst_count", 32'(event_count), 32'd0);
    chk("rst_irq",   32'(irq),         32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 3'd3, 4'hF);
    chk("held_count", 32'(event_count), 32'd0);
    chk("held_irq",   32'(irq),         32'd0);

    // 2: threshold 2 with three pulses
    pulse(3'd2, 4'hF, 1);
    chk("t2_cnt1", 32'(event_count), 32'd1);
    chk("t2_irq0", 32'(irq),         32'd0);
    pulse(3'd2, 4'h3, 1);
    chk("t2_cnt2", 32'(event_count), 32'd2);
    chk("t2_irq1", 32'(irq),         32'd1);
    pulse(3'd2, 4'h7, 1);
    chk("t2_cnt3", 32'(event_count), 32'd3);
    chk("t2_last", 32'(last_value),  32'h7);
    chk("t2_irqh", 32'(irq),         32'd1);

    // 3: ack coincident with an overflow rise
    step(0, 1, 0, 0, 3'd2, 4'h0);
    step(0, 1, 1, 1, 3'd2, 4'hA);
    chk("t3_irq",  32'(irq),         32'd0);
    chk("t3_cnt",  32'(event_count), 32'd1);
    chk("t3_last", 32'(last_value),  32'hA);
    chk("t3_busy", 32'(busy),        32'd1);

    // 4: saturation with alerts disabled
    step(0, 0, 0, 0, 3'd0, 4'h0);
    step(0, 1, 0, 0, 3'd0, 4'h0);
    for (int i = 1; i <= 9; i++) begin
      pulse(3'd0, 4'(i), 1);
      if (i == 6) chk("t4_sat6", 32'(sat), 32'd0);
      if (i == 7) chk("t4_sat7", 32'(sat), 32'd1);
    end
    chk("t4_cnt", 32'(event_count), 32'd7);
    chk("t4_irq", 32'(irq),         32'd0);

    // 5: disarm retains the count and ignores further rises
    step(1, 0, 0, 0, 3'd0, 4'h0);
    step(0, 1, 0, 0, 3'd0, 4'h0);
    pulse(3'd0, 4'h1, 1);
    pulse(3'd0, 4'h2, 1);
    step(0, 0, 0, 0, 3'd0, 4'h0);
    pulse(3'd0, 4'h3, 0);
    pulse(3'd0, 4'h4, 0);
    chk("t5_cnt",  32'(event_count), 32'd2);
    chk("t5_busy", 32'(busy),        32'd0);
    chk("t5_last", 32'(last_value),  32'h2);
    step(0, 1, 0, 0, 3'd0, 4'h0);
    chk("t5_rearm", 32'(event_count), 32'd0);

    // 6: reset while in alert
    for (int i = 0; i < 5; i++) pulse(3'd5, 4'(i), 1);
    chk("t6_cnt5", 32'(event_count), 32'd5);
    chk("t6_irq",  32'(irq),         32'd1);
    step(1, 1, 1, 0, 3'd5, 4'h9);
    chk("t6_rcnt", 32'(event_count), 32'd0);
    chk("t6_rirq", 32'(irq),         32'd0);
    chk("t6_rbsy", 32'(busy),        32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           CW'($urandom_range(0, MAX)),
           VW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
